// File: rtl/interval_param_bank_pkg.sv
// Shared definitions for the interval parameter bank: commit FSM state
// encoding and the read-path sentinel helper.
package interval_param_bank_pkg;

    typedef logic [1:0] fsm_state_t;

    localparam fsm_state_t ST_IDLE      = 2'd0;
    localparam fsm_state_t ST_STAGED    = 2'd1;
    localparam fsm_state_t ST_WAIT_SAFE = 2'd2;
    localparam fsm_state_t ST_COMMIT    = 2'd3;

    // All-ones mask of the given width (up to 32 bits); callers cast it
    // down to their value width to get the "maximum time" sentinel.
    function automatic logic [31:0] all_ones(input int width);
        logic [31:0] mask;
        mask = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/param_commit_fsm.sv
// Commit sequencer for the interval bank: tracks staged edits, holds a
// requested commit until the controller reports a phase boundary, then
// issues a single-cycle commit strobe.
module param_commit_fsm
    import interval_param_bank_pkg::*;
(
    input  logic clk,
    input  logic sys_reset,
    input  logic wr_hit,          // accepted write to an in-range address
    input  logic prg_commit,
    input  logic commit_safe,
    output logic prg_ready,
    output logic commit_pending,
    output logic commit_now
);

    fsm_state_t state_q;
    fsm_state_t state_next;

    // Next-state logic; commit requests are only honoured once something is staged.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
        state_next = state_q;
        unique case (state_q)
            ST_IDLE:      if (wr_hit)      state_next = ST_STAGED;
            ST_STAGED:    if (prg_commit)  state_next = ST_WAIT_SAFE;
            ST_WAIT_SAFE: if (commit_safe) state_next = ST_COMMIT;
            ST_COMMIT:                     state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // State register; reset always returns to IDLE, dropping any pending commit.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q <= state_next;
        end
    end

    assign prg_ready      = (state_q == ST_IDLE) || (state_q == ST_STAGED);
    assign commit_pending = (state_q == ST_WAIT_SAFE) || (state_q == ST_COMMIT);
    assign commit_now     = (state_q == ST_COMMIT);

endmodule

// File: rtl/interval_param_bank.sv
// Double-buffered bank of timer interval parameters. Software edits the
// shadow bank; the whole set is published atomically to the active bank at
// a controller phase boundary, so the controller never sees a mixed set.
module interval_param_bank
    import interval_param_bank_pkg::*;
#(
    parameter int NUM_INTERVALS = 4,
    parameter int VAL_W         = 4,
    parameter int ADDR_W        = 2,
    parameter logic [NUM_INTERVALS*VAL_W-1:0] DEFAULTS = {4'd0, 4'd2, 4'd3, 4'd6}
)(
    input  logic              clk,
    input  logic              sys_reset,
    input  logic              prg_valid,
    input  logic [ADDR_W-1:0] prg_addr,
    input  logic [VAL_W-1:0]  prg_value,
    output logic              prg_ready,
    input  logic              prg_commit,
    input  logic              commit_safe,
    output logic              commit_pending,
    output logic              prg_error,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [VAL_W-1:0]  rd_value
);

    localparam logic [VAL_W-1:0] RD_SENTINEL = VAL_W'(all_ones(VAL_W));

    logic [VAL_W-1:0] shadow_q [NUM_INTERVALS];
    logic [VAL_W-1:0] active_q [NUM_INTERVALS];
    logic [VAL_W-1:0] rd_next;

    logic addr_in_range;
    logic wr_accept;
    logic wr_hit;
    logic commit_now;

    // Zero-extend by one bit so the range test stays meaningful when the
    // address space is exactly filled.
    assign addr_in_range = ({1'b0, prg_addr} < (ADDR_W+1)'(NUM_INTERVALS));
    assign wr_accept     = prg_valid && prg_ready;
    assign wr_hit        = wr_accept && addr_in_range;

    param_commit_fsm u_fsm (
        .clk            (clk),
        .sys_reset      (sys_reset),
        .wr_hit         (wr_hit),
        .prg_commit     (prg_commit),
        .commit_safe    (commit_safe),
        .prg_ready      (prg_ready),
        .commit_pending (commit_pending),
        .commit_now     (commit_now)
    );

    // Shadow bank: in-range writes land here; a zero value restores that entry's default.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            // NOTE: banks are reset explicitly because the defaults are functional state, not don't-care storage.
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                shadow_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
            end
        end else if (wr_hit) begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                if (prg_addr == ADDR_W'(i)) begin
                    shadow_q[i] <= (prg_value != '0) ? prg_value : DEFAULTS[i*VAL_W +: VAL_W];
                end
            end
        end
    end

    // Active bank: whole-bank copy from shadow on the single commit edge.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                active_q[i] <= DEFAULTS[i*VAL_W +: VAL_W];
            end
        end else if (commit_now) begin
            for (int i = 0; i < NUM_INTERVALS; i++) begin
                active_q[i] <= shadow_q[i];
            end
        end
    end

    // Read mux; during the commit edge read the shadow so the registered
    // output switches together with the active bank.
    always_comb begin
        rd_next = RD_SENTINEL;
        for (int i = 0; i < NUM_INTERVALS; i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_next = commit_now ? shadow_q[i] : active_q[i];
            end
        end
    end

    // Registered read data and one-cycle error pulse for out-of-range writes.
    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            rd_value  <= '0;
            prg_error <= 1'b0;
        end else begin
            rd_value  <= rd_next;
            prg_error <= wr_accept && !addr_in_range;
        end
    end

endmodule

// File: doc/interval_param_bank.md
INTERVAL_PARAM_BANK -- requirements
Module: interval_param_bank

Interface
REQ-001 Parameter NUM_INTERVALS, default 4: number of interval registers, legal range 2..16.
REQ-002 Parameter VAL_W, default 4: interval value width in timer ticks.
REQ-003 Parameter ADDR_W, default 2: address width; must satisfy 2**ADDR_W >= NUM_INTERVALS.
REQ-004 Parameter DEFAULTS, default {4'd0,4'd2,4'd3,4'd6}: packed per-interval reset values, entry i at bits [i*VAL_W +: VAL_W].
REQ-005 Port list, clock and reset first:
- clk  in  1  system clock, all state on rising edge.
- sys_reset  in  1  asynchronous, active-high reset.
- prg_valid  in  1  staged-write request.
- prg_addr  in  ADDR_W  staged-write interval index.
- prg_value  in  VAL_W  staged-write value.
- prg_ready  out  1  write and commit requests accepted this cycle.
- prg_commit  in  1  request to publish the staged bank.
- commit_safe  in  1  controller FSM is at a phase boundary.
- commit_pending  out  1  commit requested, not yet applied.
- prg_error  out  1  one-cycle pulse on a write to an out-of-range address.
- rd_addr  in  ADDR_W  interval select from controller.
- rd_value  out  VAL_W  registered active value for rd_addr.

Function
REQ-006 Two banks SHALL exist: active, driving rd_value, and shadow, receiving writes.
REQ-007 A write SHALL be accepted when prg_valid and prg_ready are both 1 on a clock edge.
REQ-008 An accepted write to an address < NUM_INTERVALS SHALL update shadow[prg_addr]: prg_value if nonzero, else DEFAULTS entry.
REQ-009 An accepted write to an address >= NUM_INTERVALS SHALL leave both banks unchanged and pulse prg_error for exactly one cycle.
REQ-010 The FSM SHALL have states IDLE, STAGED, WAIT_SAFE and COMMIT.
REQ-011 FSM transitions:
- IDLE to STAGED on any accepted in-range write.
- STAGED to WAIT_SAFE on prg_commit.
- WAIT_SAFE to COMMIT when commit_safe=1.
- COMMIT to IDLE unconditionally after one cycle.
REQ-012 prg_commit in IDLE SHALL be ignored; no state change, no error.
REQ-013 In STAGED, a write and prg_commit in the same cycle SHALL apply the write, then move to WAIT_SAFE; the write is included in the commit.
REQ-014 prg_ready SHALL be 1 in IDLE and STAGED and 0 in WAIT_SAFE and COMMIT.
REQ-015 commit_pending SHALL be 1 in WAIT_SAFE and COMMIT.
REQ-016 In COMMIT, all active entries SHALL be copied from shadow in a single edge, and the bank SHALL never be partially updated.
REQ-017 commit_safe outside WAIT_SAFE SHALL have no effect.
REQ-018 rd_value SHALL equal active[rd_addr] one cycle after rd_addr is sampled.
REQ-019 rd_value SHALL be all ones for rd_addr >= NUM_INTERVALS, giving a safe maximum time.
REQ-020 The first read after COMMIT SHALL return the new value, with no stale-mix cycle.
REQ-021 The shadow bank SHALL retain its contents after a commit, so subsequent writes are deltas against the committed set.

Reset
REQ-022 sys_reset SHALL asynchronously load both banks from DEFAULTS and force the FSM to IDLE.
REQ-023 During and after reset, rd_value SHALL be 0, prg_error 0 and commit_pending 0, with prg_ready 1 from the first edge after release.
REQ-024 Reset asserted mid-WAIT_SAFE or mid-COMMIT SHALL discard the staged values; the active bank returns to DEFAULTS.

Structure
REQ-025 A shared package SHALL hold the FSM state typedef and the all-ones sentinel constant function of VAL_W.
REQ-026 The FSM SHALL be a single sub-module, param_commit_fsm, and the register banks and read mux SHALL stay in the top level.

Verification
REQ-027 Reset, then read addresses 0..3 -> rd_value reads 6, 3, 2, 0, each one cycle later.
REQ-028 Write addr0=9, then prg_commit with commit_safe=0 for 5 cycles -> rd_value(0) stays 6, prg_ready=0, commit_pending=1; raise commit_safe -> rd_value(0)=9 two cycles later.
REQ-029 Write addr1=0, then commit -> active[1]=3, the default substitution.
REQ-030 NUM_INTERVALS=3: write addr3=5 -> prg_error high for one cycle, banks unchanged; rd_addr=3 -> rd_value=4'hF.
REQ-031 Write addr2=7 with prg_commit in the same cycle, then commit_safe -> rd_value(2)=7.
REQ-032 Assert sys_reset while in WAIT_SAFE with addr0 staged at 12 -> after release rd_value(0)=6 and FSM in IDLE.
